// File: rtl/exu_div_pkg.sv
// Shared encodings between the mul/div control unit and the iterative divider.
// Op bit indices, data/address widths and a small sign helper.
package exu_div_pkg;

  localparam int REG_DATA_WIDTH = 32;
  localparam int REG_ADDR_WIDTH = 5;

  // One-hot op vector bit positions driven by control.
  localparam int DIV_OP_DIV  = 0;
  localparam int DIV_OP_DIVU = 1;
  localparam int DIV_OP_REM  = 2;
  localparam int DIV_OP_REMU = 3;
  localparam int DIV_OP_W    = 4;

  function automatic logic [REG_DATA_WIDTH-1:0] cond_neg(
    input logic [REG_DATA_WIDTH-1:0] v,
    input logic                      neg
  );
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/exu_div.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one op in flight.
// Operands are taken as magnitudes; the sign is fixed up on the final iteration.
module exu_div
  import exu_div_pkg::*;
#(
  parameter int XLEN  = REG_DATA_WIDTH,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [XLEN-1:0]           dividend_i,
  input  logic [XLEN-1:0]           divisor_i,
  input  logic [DIV_OP_W-1:0]       op_i,
  input  logic [REG_ADDR_WIDTH-1:0] reg_waddr_i,
  output logic [XLEN-1:0]           result_o,
  output logic                      ready_o,
  output logic                      busy_o,
  output logic [REG_ADDR_WIDTH-1:0] reg_waddr_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                    r_state, w_state_nxt;
  logic [CNT_W-1:0]          r_cnt;
  logic [XLEN-1:0]           r_rem, r_quo, r_dvs;
  logic                      r_neg_q, r_neg_r, r_sel_rem;
  logic [REG_ADDR_WIDTH-1:0] r_tag, r_waddr;
  logic [XLEN-1:0]           r_result;

  // Start-time decode; illegal (non one-hot) ops fall back to divu.
  logic            w_onehot, w_signed, w_sel_rem;
  logic            w_dvd_neg, w_dvs_neg;
  logic            w_div_zero, w_ovf, w_special;
  logic [XLEN-1:0] w_special_res;

  assign w_onehot   = $onehot(op_i);
  assign w_signed   = w_onehot & (op_i[DIV_OP_DIV] | op_i[DIV_OP_REM]);
  assign w_sel_rem  = w_onehot & (op_i[DIV_OP_REM] | op_i[DIV_OP_REMU]);
  assign w_dvd_neg  = w_signed & dividend_i[XLEN-1];
  assign w_dvs_neg  = w_signed & divisor_i[XLEN-1];
  assign w_div_zero = (divisor_i == '0);
  assign w_ovf      = w_signed && (dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                      && (divisor_i == '1);
  assign w_special  = w_div_zero | w_ovf;

  always_comb begin
    w_special_res = '0;
    if (w_div_zero) w_special_res = w_sel_rem ? dividend_i : '1;
    else            w_special_res = w_sel_rem ? '0 : dividend_i;
  end

  // One restoring step: the shifted partial remainder needs XLEN+1 bits
  // because divisors above 2^(XLEN-1) can exceed it after the shift.
  logic [XLEN:0]   w_trial;
  logic            w_ge, w_last;
  logic [XLEN-1:0] w_rem_nxt, w_quo_nxt, w_final;

  assign w_trial   = {r_rem, r_quo[XLEN-1]} - {1'b0, r_dvs};
  assign w_ge      = ~w_trial[XLEN];
  assign w_rem_nxt = w_ge ? w_trial[XLEN-1:0] : {r_rem[XLEN-2:0], r_quo[XLEN-1]};
  assign w_quo_nxt = {r_quo[XLEN-2:0], w_ge};
  assign w_last    = (r_cnt == CNT_W'(XLEN-1));
  assign w_final   = r_sel_rem ? cond_neg(w_rem_nxt, r_neg_r)
                               : cond_neg(w_quo_nxt, r_neg_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start_i) w_state_nxt = w_special ? S_DONE : S_CALC;
      S_CALC: begin
        if (!start_i)    w_state_nxt = S_IDLE;
        else if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvs     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_sel_rem <= 1'b0;
      r_tag     <= '0;
      r_waddr   <= '0;
      r_result  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start_i) begin
          r_tag     <= reg_waddr_i;
          r_sel_rem <= w_sel_rem;
          r_neg_q   <= w_dvd_neg ^ w_dvs_neg;
          r_neg_r   <= w_dvd_neg;
          r_cnt     <= '0;
          r_rem     <= '0;
          r_quo     <= cond_neg(dividend_i, w_dvd_neg);
          r_dvs     <= cond_neg(divisor_i, w_dvs_neg);
          if (w_special) begin
            r_result <= w_special_res;
            r_waddr  <= reg_waddr_i;
          end
        end
        S_CALC: if (start_i) begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_result <= w_final;
            r_waddr  <= r_tag;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o      = (r_state == S_CALC);
  assign ready_o     = (r_state == S_DONE);
  assign result_o    = r_result;
  assign reg_waddr_o = r_waddr;

  op_onehot_a: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == S_IDLE && start_i) |-> $onehot(op_i));

endmodule

// File: doc/exu_div.md
Name: exu_div

Overview:
- Iterative radix-2 restoring divider in the EXU, directly downstream of the mul/div control unit.
- Consumes its start, operand, one-hot op and write-address outputs.
- Returns busy, ready, result and a tagged write address, which the control unit uses for hold and write-back.
- Executes RV32M DIV/DIVU/REM/REMU; one operation in flight.

Parameters:
- XLEN, 32, operand/result width; must equal REG_DATA_WIDTH.
- CNT_W, 5, iteration counter width; must equal log2(XLEN).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  DivStart/DivStop level; held high by control for the whole operation
- dividend_i  in  XLEN  rs1 value
- divisor_i  in  XLEN  rs2 value
- op_i  in  4  one-hot: [0]=div, [1]=divu, [2]=rem, [3]=remu
- reg_waddr_i  in  REG_ADDR_WIDTH  destination register tag
- result_o  out  XLEN  quotient or remainder
- ready_o  out  1  DivResultReady, one-cycle pulse
- busy_o  out  1  iteration in progress
- reg_waddr_o  out  REG_ADDR_WIDTH  tag latched at start

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - result_o=0, ready_o=0, busy_o=0, reg_waddr_o=0.
  - All internal registers cleared.
- States: IDLE, CALC, DONE. Outputs are registered: busy_o=(state==CALC), ready_o=(state==DONE).
- IDLE, start_i=1:
  - Latch op_i and reg_waddr_i.
  - Signed ops (div, rem): latch operand magnitudes plus two sign flags.
    - neg_q = sign(dividend) XOR sign(divisor).
    - neg_r = sign(dividend).
  - Special case, divisor==0:
    - Quotient = all ones.
    - Remainder = original dividend.
    - Go to DONE; busy never asserts.
  - Special case, signed overflow (dividend=0x8000_0000, divisor=0xFFFF_FFFF, op div/rem):
    - Quotient = 0x8000_0000, remainder = 0.
    - Go to DONE.
  - Otherwise: clear counter and partial remainder, go to CALC.
- CALC, one iteration per cycle for XLEN cycles (count 0..XLEN-1):
  - Shift {rem, quo} left by 1.
  - Trial subtract divisor from the upper half (XLEN+1-bit arithmetic).
  - If non-negative, commit the difference and set quo LSB=1.
  - At count==XLEN-1:
    - Apply sign fix: quotient negated if neg_q, remainder negated if neg_r.
    - Select quotient (div/divu) or remainder (rem/remu) into result_o.
    - Go to DONE.
- DONE:
  - ready_o=1 for exactly one cycle; result_o and reg_waddr_o are valid.
  - Return to IDLE unconditionally.
  - start_i is ignored in DONE; control drops it combinationally on seeing ready.
- Latency, start sampled in cycle T:
  - Normal: busy_o high T+1..T+32, ready_o at T+33.
  - Special cases: ready_o at T+1.
- Abort: start_i=0 while in CALC (interrupt path forces DivStop):
  - Return to IDLE next cycle.
  - No ready_o pulse; result_o and reg_waddr_o keep their previous values.
- start_i=0 in IDLE: no action.
- Back-to-back: a new start_i in the IDLE cycle immediately after DONE is accepted normally.
- Operand changes while in CALC are ignored; only values latched at start are used.
- result_o and reg_waddr_o hold their last values until the next completion.
- Reset mid-operation: immediate return to the reset values above.
- op_i not one-hot (zero or multiple bits): treated as divu, result = quotient. Not legal from control; covered by an assertion.

Decomposition:
- defines.v (existing shared header) holds DivStart, DivStop, DivResultReady, REG_DATA_WIDTH and REG_ADDR_WIDTH.
- Add DIV_OP_DIV/DIVU/REM/REMU bit-index constants to defines.v so control and divider share one encoding.
- State encodings are local parameters in exu_div.
- No sub-module required; the single-step trial-subtract is inline combinational logic.

Test Plan:
- 100 divu 7: start held → busy 32 cycles, ready at T+33, result 14 (0x0E); with op rem: result 2; reg_waddr_o equals the latched tag (e.g. 5).
- div −7 by 2 (0xFFFF_FFF9, 2) → result 0xFFFF_FFFD (−3); rem → 0xFFFF_FFFF (−1); remu 0xFFFF_FFF9 by 2 → 1.
- divisor 0: div 0x1234 → 0xFFFF_FFFF at T+1; rem → 0x1234; busy_o never high.
- Overflow: div 0x8000_0000 by 0xFFFF_FFFF → 0x8000_0000; rem → 0; ready at T+1.
- Abort: drop start_i at CALC cycle 10 → IDLE next cycle, no ready pulse, result_o unchanged; a following divu 9/3 returns 3.
- Reset: assert rst_n=0 mid-CALC → busy_o=0, ready_o=0, result_o=0 asynchronously; random back-to-back ops checked against a reference model (10k vectors).
